debounce: RTL and testbench

//  Mechanical push-button debouncer for board-level user inputs (e.g. SRAM demo control keys).

---
 rtl/debounce_if.sv | 33 +++
 rtl/debounce.sv | 155 +++++++++++++++
 tb/tb_debounce.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/debounce_if.sv
// -----------------------------------------------------------------------------
// debounce_if
//   Groups the button-facing signals of the debouncer.
//
//   Signals
//     btn_in     raw asynchronous button level, 1 = pressed (driven by master)
//     btn_out    debounced, registered level                (driven by slave)
//     btn_pulse  one-cycle strobe on an accepted press      (driven by slave,
//                present only when DEBOUNCE_PULSE_EN is defined)
//
//   Modports
//     master : the side that owns the raw button and consumes the clean level
//     slave  : the debouncer itself
//
//   Optional feature macro: DEBOUNCE_PULSE_EN
//
//   Handshake: there is no valid/ready pair. btn_in is a free-running level
//   sampled every clock; btn_out and btn_pulse are levels updated only on the
//   rising edge of clk and are always valid outside reset.
// -----------------------------------------------------------------------------
interface debounce_if;
    logic btn_in;
    logic btn_out;
`ifdef DEBOUNCE_PULSE_EN
    logic btn_pulse;

    modport master (output btn_in, input  btn_out, input  btn_pulse);
    modport slave  (input  btn_in, output btn_out, output btn_pulse);
`else
    modport master (output btn_in, input  btn_out);
    modport slave  (input  btn_in, output btn_out);
`endif
endinterface

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
//   Push-button debouncer. The raw button level is brought into the clk domain
//   through a two-flop synchroniser, then a four-state FSM only accepts a new
//   level after it has been seen for DEBOUNCE_CYCLES consecutive clocks.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable cycles needed to accept a new level (>= 2)
//     CNT_W            stability counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
//   Ports
//     clk      in   system clock, rising edge
//     rst      in   synchronous, active-high reset
//     bus      slave modport of debounce_if (btn_in / btn_out / btn_pulse)
//     state_o  out  current FSM state (debug observation)
//                   0 = ST_LOW, 1 = WAIT_HIGH, 2 = ST_HIGH, 3 = WAIT_LOW
//
//   Optional feature macro: DEBOUNCE_PULSE_EN
//     When defined, bus.btn_pulse is high for exactly one cycle after the edge
//     on which btn_out rises. No pulse is produced on release.
// -----------------------------------------------------------------------------
module debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    debounce_if.slave  bus,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        WAIT_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Last count value before acceptance; the WAIT state is entered with a
    // count of 1, so acceptance happens on the DEBOUNCE_CYCLES-th stable sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_q;
    logic             btn_d;

    // Synchroniser: everything downstream looks only at s2_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
        end
    end

    // Next-state logic. The counter is cleared on every state change, so it
    // can never exceed CNT_LAST and never wraps. Acceptance is checked before
    // anything else in a stable sample, so a level change arriving on the same
    // edge is seen by the new state on the following edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        btn_d   = btn_q;
        unique case (state_q)
            ST_LOW: begin
                btn_d = 1'b0;
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    btn_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                btn_d = 1'b1;
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    btn_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                btn_d   = 1'b0;
            end
        endcase
    end

    assign bus.btn_out = btn_q;
    assign state_o     = state_q;

`ifdef DEBOUNCE_PULSE_EN
    logic pulse_q;
    logic pulse_d;

    // Registered together with btn_q, so the strobe lines up with the cycle
    // in which btn_out first reads 1.
    always_comb begin
        pulse_d = (state_q == WAIT_HIGH) && s2_q && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign bus.btn_pulse = pulse_q;
`endif

endmodule

// File: tb/tb_debounce.sv
// -----------------------------------------------------------------------------
// tb_debounce
//   Directed bench for debounce. Two instances share the same raw button:
//   dut_a with DEBOUNCE_CYCLES=16 and dut_b with the minimum legal value 2.
//   Inputs change 1 ns after a rising edge, so the next edge is the first one
//   at which s1 samples the new level (e0). After k calls of step() the edges
//   e0..e0+k-1 have passed; a level accepted on edge e0+N+1 is therefore
//   visible from step k = N+2 onwards (18 for N=16, 4 for N=2).
// -----------------------------------------------------------------------------
module tb_debounce;

    localparam int N_A = 16;
    localparam int W_A = 5;
    localparam int N_B = 2;
    localparam int W_B = 2;

    logic       clk;
    logic       rst;
    logic [1:0] state_a;
    logic [1:0] state_b;

    int n_checks = 0;
    int n_errors = 0;

    debounce_if bus_a ();
    debounce_if bus_b ();

    debounce #(.DEBOUNCE_CYCLES(N_A), .CNT_W(W_A)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_a),
        .state_o (state_a)
    );

    debounce #(.DEBOUNCE_CYCLES(N_B), .CNT_W(W_B)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_b),
        .state_o (state_b)
    );

    // Clock: 100 MHz.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic v);
        bus_a.btn_in = v;
        bus_b.btn_in = v;
    endtask

    initial begin
        rst = 1'b1;
        set_btn(1'b0);

        // Reset for two cycles, then 100 quiet cycles.
        step();
        step();
        check("rst_out_a", 32'(bus_a.btn_out), 0);
        check("rst_out_b", 32'(bus_b.btn_out), 0);
        check("rst_state_a", 32'(state_a), 0);
`ifdef DEBOUNCE_PULSE_EN
        check("rst_pulse_a", 32'(bus_a.btn_pulse), 0);
`endif
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            check("idle_out_a", 32'(bus_a.btn_out), 0);
        end
        check("idle_state_a", 32'(state_a), 0);

        // Clean press held 100 cycles.
        set_btn(1'b1);
        for (int k = 1; k <= 100; k++) begin
            step();
            check("press_out_a", 32'(bus_a.btn_out), 32'(k >= N_A + 2));
            check("press_out_b", 32'(bus_b.btn_out), 32'(k >= N_B + 2));
`ifdef DEBOUNCE_PULSE_EN
            check("press_pulse_a", 32'(bus_a.btn_pulse), 32'(k == N_A + 2));
`endif
        end
        check("press_state_a", 32'(state_a), 2);

        // Clean release: same latency, no pulse.
        set_btn(1'b0);
        for (int k = 1; k <= 30; k++) begin
            step();
            check("rel_out_a", 32'(bus_a.btn_out), 32'(k < N_A + 2));
            check("rel_out_b", 32'(bus_b.btn_out), 32'(k < N_B + 2));
`ifdef DEBOUNCE_PULSE_EN
            check("rel_pulse_a", 32'(bus_a.btn_pulse), 0);
`endif
        end
        check("rel_state_a", 32'(state_a), 0);

        // Bounce: toggle every 3 cycles for 60 cycles, then hold high.
        for (int k = 0; k < 60; k++) begin
            set_btn(((k / 3) % 2) == 0);
            step();
            check("bounce_out_a", 32'(bus_a.btn_out), 0);
        end
        set_btn(1'b1);
        for (int k = 1; k <= 30; k++) begin
            step();
            check("bounce_hold_a", 32'(bus_a.btn_out), 32'(k >= N_A + 2));
`ifdef DEBOUNCE_PULSE_EN
            check("bounce_pulse_a", 32'(bus_a.btn_pulse), 32'(k == N_A + 2));
`endif
        end

        // Release glitch while high: 10 cycles low, then high again.
        set_btn(1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("glitch_low_a", 32'(bus_a.btn_out), 1);
        end
        set_btn(1'b1);
        for (int k = 1; k <= 30; k++) begin
            step();
            check("glitch_high_a", 32'(bus_a.btn_out), 1);
`ifdef DEBOUNCE_PULSE_EN
            check("glitch_pulse_a", 32'(bus_a.btn_pulse), 0);
`endif
        end
        check("glitch_state_a", 32'(state_a), 2);

        // Return to low, then reset in the middle of a press wait.
        set_btn(1'b0);
        for (int k = 1; k <= 30; k++) begin
            step();
        end
        check("pre_rst_out_a", 32'(bus_a.btn_out), 0);
        set_btn(1'b1);
        for (int k = 1; k <= 10; k++) begin
            step();
        end
        check("mid_wait_state_a", 32'(state_a), 1);
        check("mid_wait_out_a", 32'(bus_a.btn_out), 0);
        rst = 1'b1;
        step();
        check("mid_rst_out_a", 32'(bus_a.btn_out), 0);
        check("mid_rst_state_a", 32'(state_a), 0);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            check("post_rst_out_a", 32'(bus_a.btn_out), 32'(k >= N_A + 2));
            check("post_rst_out_b", 32'(bus_b.btn_out), 32'(k >= N_B + 2));
`ifdef DEBOUNCE_PULSE_EN
            check("post_rst_pulse_a", 32'(bus_a.btn_pulse), 32'(k == N_A + 2));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
